led_blink_scheduler: RTL

- Multi-channel LED blink controller driven by the shared 1 kHz enable tick from the clock-enable generator.
- Holds a programmable half-period, in milliseconds, and an enable bit for each LED channel. Toggles each enabled LED when its tick count expires.
- Sits between the tick generator and the board LED pins. Configured through a simple single-cycle register-write port from the top-level or bus core.

---
 rtl/led_blink_scheduler.sv | 94 +++++++++
 1 files changed

// File: rtl/led_blink_scheduler.sv
// Multi-channel LED blink controller: each enabled channel toggles its LED every
// period[i] ticks of the shared 1 ms enable, with a single-cycle register-write port.
module led_blink_scheduler #(
    parameter int unsigned NUM_LEDS     = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RESET_PERIOD = 500,
    localparam int unsigned AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_1ms,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [AW-1:0]       wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    input  logic                restart,
    output logic [NUM_LEDS-1:0] leds,
    output logic [NUM_LEDS-1:0] en_mask
);

    localparam logic [CNT_W-1:0] RST_PER = CNT_W'(RESET_PERIOD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]    period_q [NUM_LEDS];
    logic [CNT_W-1:0]    cnt_q    [NUM_LEDS];
    logic [CNT_W-1:0]    period_d [NUM_LEDS];
    logic [CNT_W-1:0]    cnt_d    [NUM_LEDS];
    logic [NUM_LEDS-1:0] leds_d;
    logic [NUM_LEDS-1:0] mask_d;
    logic [NUM_LEDS-1:0] per_hit;
    logic                mask_wr;
    logic                per_wr;

    // Decode the write port; out-of-range period addresses are dropped.
    always_comb begin
        mask_wr = wr_en & wr_sel;
        per_wr  = wr_en & ~wr_sel & (32'(wr_addr) < NUM_LEDS);
        mask_d  = mask_wr ? wr_data[NUM_LEDS-1:0] : en_mask;
        per_hit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            per_hit[i] = per_wr & (wr_addr == AW'(i));
        end
    end

    // Per-channel next state: restart > mask/period write > tick.
    always_comb begin
        leds_d = leds;
        for (int i = 0; i < NUM_LEDS; i++) begin
            period_d[i] = per_hit[i] ? wr_data : period_q[i];
            cnt_d[i]    = cnt_q[i];
            if (restart) begin
                cnt_d[i]  = '0;
                leds_d[i] = mask_d[i] & (period_d[i] == '0);
            end else if (!mask_d[i]) begin
                cnt_d[i]  = '0;
                leds_d[i] = 1'b0;
            end else if (period_d[i] == '0) begin
                cnt_d[i]  = '0;
                leds_d[i] = 1'b1;
            end else if (mask_wr && !en_mask[i]) begin
                cnt_d[i]  = '0;
                leds_d[i] = 1'b0;
            end else if (per_hit[i]) begin
                cnt_d[i]  = '0;
            end else if (tick_1ms) begin
                if (cnt_q[i] >= period_q[i] - ONE) begin
                    cnt_d[i]  = '0;
                    leds_d[i] = ~leds[i];
                end else begin
                    cnt_d[i]  = cnt_q[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds    <= '0;
            en_mask <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                period_q[i] <= RST_PER;
                cnt_q[i]    <= '0;
            end
        end else begin
            leds    <= leds_d;
            en_mask <= mask_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

endmodule
